// File: rtl/clock_divider_100mhz_to_1hz.sv
// clock_divider_100mhz_to_1hz: divides the system clock by 2*HALF_COUNT into a 50% duty square wave
module clock_divider_100mhz_to_1hz #(
  parameter int unsigned HALF_COUNT = 50000000
) (
  output logic clock_1Hz,
  input  logic enable,
  input  logic clock,
  input  logic clear_n
);
  localparam logic [25:0] LAST = 26'(HALF_COUNT - 1);
  logic [25:0] count_50000000;
  logic [25:0] count_d;
  logic        out_q;
  logic        out_d;
  logic        wrap;
  // Anything at or past the terminal value wraps, so a corrupted count self-recovers in one edge.
  always_comb begin
    wrap    = count_50000000 >= LAST;
    count_d = enable ? (wrap ? '0 : count_50000000 + 26'd1) : count_50000000;
    out_d   = out_q ^ (enable & wrap);
  end
  // Counter and output flop; the async clear overrides everything including an unknown enable.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      count_50000000 <= '0;
      out_q          <= 1'b0;
    end else begin
      count_50000000 <= count_d;
      out_q          <= out_d;
    end
  end
  assign clock_1Hz = out_q;
endmodule

// File: tb/tb_clock_divider_100mhz_to_1hz.sv
// tb_clock_divider_100mhz_to_1hz: directed checks of the divider with HALF_COUNT=10
module tb_clock_divider_100mhz_to_1hz;
  logic clock = 1'b1;
  logic clear_n = 1'b0;
  logic enable = 1'b0;
  logic clock_1Hz;
  int checks = 0;
  int errors = 0;
  clock_divider_100mhz_to_1hz #(.HALF_COUNT(10)) dut (
    .clock_1Hz(clock_1Hz),
    .enable(enable),
    .clock(clock),
    .clear_n(clear_n)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic edges(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  initial begin
    logic [31:0] ec;
    logic        eo;
    logic        prev;
    int          tg;
    int          hi;
    #20 enable = 1'bx;
    #30;
    chk("rst_cnt_50", 32'(dut.count_50000000), 0);
    chk("rst_out_50", 32'(clock_1Hz), 0);
    #46;
    chk("rst_cnt_96", 32'(dut.count_50000000), 0);
    chk("rst_out_96", 32'(clock_1Hz), 0);
    #1 clear_n = 1'b1;
    enable = 1'b1;
    edges(1);
    chk("first_cnt", 32'(dut.count_50000000), 1);
    chk("first_out", 32'(clock_1Hz), 0);
    edges(8);
    chk("pre_cnt", 32'(dut.count_50000000), 9);
    chk("pre_out", 32'(clock_1Hz), 0);
    edges(1);
    chk("rise_cnt", 32'(dut.count_50000000), 0);
    chk("rise_out", 32'(clock_1Hz), 1);
    chk("rise_time", 32'($time), 191);
    ec = 0;
    eo = 1'b1;
    prev = 1'b1;
    tg = 0;
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      edges(1);
      ec = (ec == 9) ? 0 : ec + 1;
      if (ec == 0) eo = ~eo;
      chk("wrap_cnt", 32'(dut.count_50000000), ec);
      chk("wrap_out", 32'(clock_1Hz), 32'(eo));
      if (clock_1Hz !== prev) tg++;
      prev = clock_1Hz;
      if (clock_1Hz === 1'b1) hi++;
    end
    chk("wrap_toggles", 32'(tg), 10);
    chk("wrap_high", 32'(hi), 50);
    edges(4);
    chk("hold_start_cnt", 32'(dut.count_50000000), 4);
    chk("hold_start_out", 32'(clock_1Hz), 1);
    enable = 1'b0;
    edges(7);
    chk("hold_cnt", 32'(dut.count_50000000), 4);
    chk("hold_out", 32'(clock_1Hz), 1);
    enable = 1'b1;
    edges(5);
    chk("resume_cnt", 32'(dut.count_50000000), 9);
    chk("resume_out", 32'(clock_1Hz), 1);
    edges(1);
    chk("resume_tog_cnt", 32'(dut.count_50000000), 0);
    chk("resume_tog_out", 32'(clock_1Hz), 0);
    edges(10);
    chk("mid_hi_out", 32'(clock_1Hz), 1);
    edges(6);
    chk("mid_cnt", 32'(dut.count_50000000), 6);
    chk("mid_out", 32'(clock_1Hz), 1);
    #2 clear_n = 1'b0;
    #1;
    chk("async_cnt", 32'(dut.count_50000000), 0);
    chk("async_out", 32'(clock_1Hz), 0);
    clear_n = 1'b1;
    edges(9);
    chk("post_rst_cnt", 32'(dut.count_50000000), 9);
    chk("post_rst_out", 32'(clock_1Hz), 0);
    edges(1);
    chk("post_rst_tog_cnt", 32'(dut.count_50000000), 0);
    chk("post_rst_tog_out", 32'(clock_1Hz), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
